// File: rtl/debug_console_if.sv
// ---------------------------------------------------------------------------
// debug_console_if
// Bundles the register bus and the output byte stream of the debug console.
//   en_i / we_i / addr_i / data_i : bus access strobe, direction, address, data
//   rdata_o                       : registered read data (1-cycle latency)
//   out_valid_o / out_ready_i     : output byte handshake
//   out_data_o / out_chan_o       : output byte and its source channel
//   out_last_o                    : byte closes its committed segment
// Modports: master = bus host / stream consumer, slave = the console itself.
// ---------------------------------------------------------------------------
interface debug_console_if #(
  parameter int CHANNELS = 4
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic          en_i;
  logic          we_i;
  logic [23:0]   addr_i;
  logic [31:0]   data_i;
  logic [31:0]   rdata_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [7:0]    out_data_o;
  logic [CW-1:0] out_chan_o;
  logic          out_last_o;

  modport master (
    output en_i, we_i, addr_i, data_i, out_ready_i,
    input  rdata_o, out_valid_o, out_data_o, out_chan_o, out_last_o
  );

  modport slave (
    input  en_i, we_i, addr_i, data_i, out_ready_i,
    output rdata_o, out_valid_o, out_data_o, out_chan_o, out_last_o
  );
endinterface

// File: rtl/debug_console.sv
// ---------------------------------------------------------------------------
// debug_console
// Multi-channel byte console. Each channel owns a FIFO of DEPTH bytes that
// software fills through bus writes. Bytes become visible on the output
// stream only once committed (by a 00/0A terminator or by filling the FIFO).
// A round-robin arbiter locks onto one channel and streams its committed
// segment before moving on. Two status words report drops, full/pending
// masks, channel-0 occupancy and a hash of the node address.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : debug_console_if.slave (register bus + output byte stream)
// ---------------------------------------------------------------------------
module debug_console #(
  parameter logic [15:0] ADDRESS  = 16'h0000,
  parameter int          CHANNELS = 4,
  parameter int          DEPTH    = 64
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  debug_console_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {IDLE, LOCK} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   rrPtr_q, rrPtr_d;
  logic [15:0]     dropCnt_q, dropCnt_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [7:0]      mem_q       [CHANNELS][DEPTH];
  logic [AW-1:0]   wrPtr_q     [CHANNELS];
  logic [AW-1:0]   wrPtr_d     [CHANNELS];
  logic [AW-1:0]   rdPtr_q     [CHANNELS];
  logic [AW-1:0]   rdPtr_d     [CHANNELS];
  logic [OW-1:0]   occ_q       [CHANNELS];
  logic [OW-1:0]   occ_d       [CHANNELS];
  logic [OW-1:0]   committed_q [CHANNELS];
  logic [OW-1:0]   committed_d [CHANNELS];

  logic [CHANNELS-1:0] pushReq;
  logic [CHANNELS-1:0] pushOk;
  logic [CHANNELS-1:0] pop;
  logic [CHANNELS-1:0] commitHit;
  logic                drop;
  logic                clearDrop;
  logic                readReq;
  logic                outValid;
  logic                lastByte;
  logic [7:0]          headByte;
  logic [7:0]          fullMask;
  logic [7:0]          pendMask;
  logic [7:0]          occ0Byte;
  logic [31:0]         occ0Wide;
  logic [31:0]         readVal;
  logic [CW-1:0]       cand;
  logic                found;
  logic                unusedDataBits;

  // Only the low byte of write data ever reaches a FIFO.
  assign unusedDataBits = ^bus.data_i[31:8];

  assign clearDrop = bus.en_i & bus.we_i & (bus.addr_i == 24'h000104);
  assign readReq   = bus.en_i & ~bus.we_i;

  // The arbiter presents the granted FIFO head; last is taken from the live
  // committed count so bytes committed mid-segment extend it.
  assign outValid = (state_q == LOCK);
  assign headByte = mem_q[grant_q][rdPtr_q[grant_q]];
  assign lastByte = (committed_q[grant_q] == OW'(1));

  assign bus.out_valid_o = outValid;
  assign bus.out_data_o  = outValid ? headByte : 8'h00;
  assign bus.out_chan_o  = outValid ? grant_q : '0;
  assign bus.out_last_o  = outValid & lastByte;
  assign bus.rdata_o     = rdata_q;

  // Per-channel push/pop decode and FIFO bookkeeping. Space is judged on the
  // pre-edge occupancy, so a pop on the same edge never rescues a push. A
  // commit snaps committed[c] to the post-edge occupancy, which also pulls in
  // any earlier unterminated bytes of that channel.
  always_comb begin
    pushReq   = '0;
    pushOk    = '0;
    pop       = '0;
    commitHit = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pushReq[c] = bus.en_i & bus.we_i & (bus.addr_i == 24'(4 * c));
      pushOk[c]  = pushReq[c] & (occ_q[c] < OW'(DEPTH));
      pop[c]     = outValid & bus.out_ready_i & (grant_q == CW'(c));
      commitHit[c] = pushOk[c] & ((bus.data_i[7:0] == 8'h00) ||
                                  (bus.data_i[7:0] == 8'h0A) ||
                                  (occ_q[c] == OW'(DEPTH - 1)));
      wrPtr_d[c] = pushOk[c] ? wrPtr_q[c] + AW'(1) : wrPtr_q[c];
      rdPtr_d[c] = pop[c] ? rdPtr_q[c] + AW'(1) : rdPtr_q[c];
      occ_d[c]   = occ_q[c] + OW'(pushOk[c]) - OW'(pop[c]);
      committed_d[c] = commitHit[c] ? occ_d[c]
                                    : committed_q[c] - OW'(pop[c]);
    end
    drop = |(pushReq & ~pushOk);
  end

  // Drop counter: a clear wins over the old count, but a drop on the very
  // same edge is still recorded as the first drop after the clear.
  always_comb begin
    dropCnt_d = dropCnt_q;
    if (clearDrop) begin
      dropCnt_d = drop ? 16'd1 : 16'd0;
    end else if (drop && (dropCnt_q != 16'hFFFF)) begin
      dropCnt_d = dropCnt_q + 16'd1;
    end
  end

  // Status words. Channel-0 occupancy saturates at FF so DEPTH=256 still
  // fits in one byte.
  always_comb begin
    fullMask = '0;
    pendMask = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      fullMask[c] = (occ_q[c] == OW'(DEPTH));
      pendMask[c] = (committed_q[c] != '0);
    end
    occ0Wide = 32'(occ_q[0]);
    occ0Byte = (occ0Wide > 32'd255) ? 8'hFF : occ0Wide[7:0];
    case (bus.addr_i)
      24'h000100: readVal = {dropCnt_q, ADDRESS[15:8] ^ ADDRESS[7:0], fullMask};
      24'h000104: readVal = {pendMask, 16'h0000, occ0Byte};
      default:    readVal = 32'h0;
    endcase
    rdata_d = readReq ? readVal : rdata_q;
  end

  // Arbiter next state. In IDLE the search starts just after the last
  // granted channel; leaving LOCK takes one edge, which guarantees the idle
  // cycle between segments.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rrPtr_d = rrPtr_q;
    found   = 1'b0;
    cand    = '0;
    case (state_q)
      IDLE: begin
        for (int k = 0; k < CHANNELS; k++) begin
          cand = CW'((int'(rrPtr_q) + k) % CHANNELS);
          if (!found && (committed_q[cand] != '0)) begin
            found   = 1'b1;
            grant_d = cand;
            rrPtr_d = (cand == CW'(CHANNELS - 1)) ? '0 : cand + CW'(1);
            state_d = LOCK;
          end
        end
      end
      LOCK: begin
        if (bus.out_ready_i && lastByte) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // FIFO storage carries no reset: emptiness comes from the pointers and
  // occupancy, so stale contents are never observable.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (pushOk[c]) begin
        mem_q[c][wrPtr_q[c]] <= bus.data_i[7:0];
      end
    end
  end

  // All control state. Reset empties every channel, parks the arbiter and
  // points round-robin at channel 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rrPtr_q   <= '0;
      dropCnt_q <= '0;
      rdata_q   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        wrPtr_q[c]     <= '0;
        rdPtr_q[c]     <= '0;
        occ_q[c]       <= '0;
        committed_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rrPtr_q   <= rrPtr_d;
      dropCnt_q <= dropCnt_d;
      rdata_q   <= rdata_d;
      for (int c = 0; c < CHANNELS; c++) begin
        wrPtr_q[c]     <= wrPtr_d[c];
        rdPtr_q[c]     <= rdPtr_d[c];
        occ_q[c]       <= occ_d[c];
        committed_q[c] <= committed_d[c];
      end
    end
  end
endmodule

// File: tb/tb_debug_console.sv
// ---------------------------------------------------------------------------
// tb_debug_console
// Directed bench for debug_console (ADDRESS=16'h1234, CHANNELS=4, DEPTH=16).
// Expected output bytes are queued when the stimulus is driven and checked
// by a monitor when the console hands them over.
// ---------------------------------------------------------------------------
module tb_debug_console;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [10:0] expQ[$];
  logic [10:0] expWord;
  logic [10:0] heldWord;
  logic        holdPending = 1'b0;
  logic        gapPending = 1'b0;
  logic        toggleReady = 1'b0;
  logic        sawValid;

  debug_console_if #(.CHANNELS(4)) bus ();

  debug_console #(
    .ADDRESS (16'h1234),
    .CHANNELS(4),
    .DEPTH   (16)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Safety net so a stuck design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, let the next rising edge sample it, then release.
  task automatic applyStimulus(input logic en, input logic we,
                               input logic [23:0] addr, input logic [31:0] data);
    bus.en_i   = en;
    bus.we_i   = we;
    bus.addr_i = addr;
    bus.data_i = data;
    if (toggleReady) bus.out_ready_i = ~bus.out_ready_i;
    @(posedge clk);
    #1;
    bus.en_i = 1'b0;
    bus.we_i = 1'b0;
  endtask

  task automatic writeChan(input int c, input logic [7:0] b);
    applyStimulus(1'b1, 1'b1, 24'(4 * c), {24'h0, b});
  endtask

  task automatic readCheck(input logic [23:0] addr, input logic [31:0] exp,
                           input string tag);
    applyStimulus(1'b1, 1'b0, addr, 32'h0);
    checkOutput(tag, bus.rdata_o, exp);
  endtask

  task automatic expectByte(input int c, input logic [7:0] d, input logic last);
    expQ.push_back({last, 2'(c), d});
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      if (toggleReady) bus.out_ready_i = ~bus.out_ready_i;
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_remaining", 32'(expQ.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor, sampling on the falling edge. A handshake seen here is
  // the byte popped at the next rising edge. It also checks that a stalled
  // byte is held unchanged and that every segment is followed by an idle
  // cycle. Everything is skipped while reset is asserted.
  always @(negedge clk) begin
    if (!rst_n) begin
      holdPending = 1'b0;
      gapPending  = 1'b0;
    end else begin
      if (gapPending) begin
        checkOutput("idle_gap", {31'h0, bus.out_valid_o}, 32'h0);
        gapPending = 1'b0;
      end
      if (holdPending) begin
        checkOutput("hold_stable",
                    {20'h0, bus.out_valid_o, bus.out_last_o, bus.out_chan_o, bus.out_data_o},
                    {20'h0, 1'b1, heldWord});
        holdPending = 1'b0;
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        checkOutput("byte_expected", 32'(expQ.size() != 0), 32'h1);
        if (expQ.size() != 0) begin
          expWord = expQ.pop_front();
          checkOutput("out_byte",
                      {20'h0, bus.out_valid_o, bus.out_last_o, bus.out_chan_o, bus.out_data_o},
                      {20'h0, 1'b1, expWord});
          if (expWord[10]) gapPending = 1'b1;
        end
      end else if (bus.out_valid_o) begin
        holdPending = 1'b1;
        heldWord    = {bus.out_last_o, bus.out_chan_o, bus.out_data_o};
      end
    end
  end

  // Directed sequence.
  initial begin
    bus.en_i        = 1'b0;
    bus.we_i        = 1'b0;
    bus.addr_i      = 24'h0;
    bus.data_i      = 32'h0;
    bus.out_ready_i = 1'b1;

    // Reset values.
    #2;
    checkOutput("reset_stream",
                {20'h0, bus.out_valid_o, bus.out_last_o, bus.out_chan_o, bus.out_data_o},
                32'h0);
    checkOutput("reset_rdata", bus.rdata_o, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // "Hi\n" on channel 0, valid exactly two edges after the newline.
    $display("[TB] step: Hi newline on ch0");
    expectByte(0, 8'h48, 1'b0);
    expectByte(0, 8'h69, 1'b0);
    expectByte(0, 8'h0A, 1'b1);
    writeChan(0, 8'h48);
    writeChan(0, 8'h69);
    writeChan(0, 8'h0A);
    checkOutput("latency_edge_n", {31'h0, bus.out_valid_o}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("latency_edge_n1", {31'h0, bus.out_valid_o}, 32'h1);
    waitDrain(20);

    // Unterminated bytes stay hidden until a 00 arrives.
    $display("[TB] step: uncommitted ab on ch1");
    writeChan(1, 8'h61);
    writeChan(1, 8'h62);
    sawValid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      sawValid = sawValid | bus.out_valid_o;
    end
    @(posedge clk);
    #1;
    checkOutput("no_uncommitted_output", {31'h0, sawValid}, 32'h0);
    expectByte(1, 8'h61, 1'b0);
    expectByte(1, 8'h62, 1'b0);
    expectByte(1, 8'h00, 1'b1);
    writeChan(1, 8'h00);
    waitDrain(20);

    // Fill channel 2, overflow by one, inspect status, then drain.
    $display("[TB] step: fill and overflow ch2");
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      expectByte(2, 8'h41, (i == 15));
      writeChan(2, 8'h41);
    end
    writeChan(2, 8'h41);
    readCheck(24'h000100, 32'h0001_2604, "status_after_drop");
    readCheck(24'h000104, 32'h0400_0000, "pending_after_fill");
    applyStimulus(1'b1, 1'b1, 24'h000104, 32'h0);
    readCheck(24'h000100, 32'h0000_2604, "drop_cleared");
    bus.out_ready_i = 1'b1;
    waitDrain(60);

    // Three channels commit together while ready toggles.
    $display("[TB] step: round robin ch0 ch1 ch3 with toggling ready");
    for (int c = 0; c < 4; c++) begin
      if (c != 2) begin
        expectByte(c, 8'h78, 1'b0);
        expectByte(c, 8'h0A, 1'b1);
      end
    end
    toggleReady = 1'b1;
    writeChan(0, 8'h78);
    writeChan(0, 8'h0A);
    writeChan(1, 8'h78);
    writeChan(1, 8'h0A);
    writeChan(3, 8'h78);
    writeChan(3, 8'h0A);
    waitDrain(100);
    toggleReady = 1'b0;

    // Reset in the middle of a stalled three-byte segment.
    $display("[TB] step: reset mid-segment");
    bus.out_ready_i = 1'b0;
    writeChan(1, 8'h70);
    writeChan(1, 8'h71);
    writeChan(1, 8'h0A);
    @(posedge clk);
    #1;
    checkOutput("segment_before_reset", {31'h0, bus.out_valid_o}, 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async_stream",
                {20'h0, bus.out_valid_o, bus.out_last_o, bus.out_chan_o, bus.out_data_o},
                32'h0);
    checkOutput("reset_async_rdata", bus.rdata_o, 32'h0);
    applyStimulus(1'b1, 1'b1, 24'h000000, 32'h0A);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    readCheck(24'h000100, 32'h0000_2600, "status_after_reset");
    readCheck(24'h000104, 32'h0000_0000, "pending_after_reset");
    bus.out_ready_i = 1'b1;
    sawValid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      sawValid = sawValid | bus.out_valid_o;
    end
    @(posedge clk);
    #1;
    checkOutput("no_output_after_reset", {31'h0, sawValid}, 32'h0);

    // Ignored writes, occupancy report, read hold and unmapped reads.
    $display("[TB] step: ignored accesses and occupancy");
    applyStimulus(1'b1, 1'b1, 24'h000010, 32'h0A);
    applyStimulus(1'b1, 1'b1, 24'h000108, 32'h0A);
    writeChan(0, 8'h61);
    writeChan(0, 8'h62);
    writeChan(0, 8'h63);
    readCheck(24'h000104, 32'h0000_0003, "occupancy_ch0");
    readCheck(24'h000100, 32'h0000_2600, "status_idle");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rdata_hold", bus.rdata_o, 32'h0000_2600);
    readCheck(24'h000200, 32'h0000_0000, "unmapped_read");
    expectByte(0, 8'h61, 1'b0);
    expectByte(0, 8'h62, 1'b0);
    expectByte(0, 8'h63, 1'b0);
    expectByte(0, 8'h0A, 1'b1);
    writeChan(0, 8'h0A);
    waitDrain(30);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/debug_console.md
DEBUG_CONSOLE -- requirements
Module: debug_console

Interface
REQ-001 Parameter ADDRESS, default 16'h0000, node address {x[15:8], y[7:0]}, reported in the status word.
REQ-002 Parameter CHANNELS, default 4, legal 1..8, number of independent byte channels.
REQ-003 Parameter DEPTH, default 64, power of two 4..256, bytes per channel FIFO.
REQ-004 clk_i  input  1  clock; single clock domain.
REQ-005 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 en_i  input  1  bus access strobe.
REQ-007 we_i  input  1  1 = write, 0 = read.
REQ-008 addr_i  input  24  byte address.
REQ-009 data_i  input  32  write data; only [7:0] is used for channel writes.
REQ-010 rdata_o  output  32  registered read data.
REQ-011 out_valid_o  output  1  output byte valid.
REQ-012 out_ready_i  input  1  consumer accepts byte.
REQ-013 out_data_o  output  8  output byte.
REQ-014 out_chan_o  output  max(1,$clog2(CHANNELS))  channel of the output byte.
REQ-015 out_last_o  output  1  byte is the last of its committed segment.

Function
REQ-016 Channel write: en_i & we_i & addr_i == 4*c (c < CHANNELS) pushes data_i[7:0] into FIFO c at the rising edge.
REQ-017 Push is accepted only if the occupancy of FIFO c before that edge is < DEPTH. A simultaneous pop does not free space for the same edge. A rejected push increments drop_cnt, a 16-bit counter that saturates at 16'hFFFF.
REQ-018 Commit rules: a pushed byte of 8'h00 or 8'h0A, or a push that makes occupancy == DEPTH, sets committed[c] equal to the post-edge occupancy (push and pop both applied). Bytes that are not committed are never output.
REQ-019 Each pop of FIFO c decrements committed[c] and occupancy[c] by 1.
REQ-020 Arbiter states:
- IDLE: at an edge with any committed[c] > 0, select the first such c in round-robin order starting after the last granted channel (channel 0 first after reset), latch it as grant, and go to LOCK.
- LOCK: out_valid_o = 1, out_chan_o = grant, out_data_o = FIFO head, out_last_o = (committed[grant] == 1).
- The segment is the committed bytes of the granted channel. A pop occurs on each edge with out_valid_o & out_ready_i. Return to IDLE on the edge that pops a byte with out_last_o = 1.
REQ-021 Latency: a committing write sampled at edge N gives out_valid_o = 1 after edge N+1 when the arbiter is IDLE. There is always at least one IDLE cycle between segments.
REQ-022 In LOCK, out_data_o, out_chan_o and out_last_o stay stable while out_valid_o & !out_ready_i.
REQ-023 Bytes committed to the granted channel during LOCK extend the current segment. out_last_o is recomputed from the live committed[grant].
REQ-024 Read: en_i & !we_i registers rdata_o at the edge, 1-cycle latency.
- addr 24'h000100: {drop_cnt[15:0], ADDRESS[15:8] xor ADDRESS[7:0], full mask[7:0]}.
- addr 24'h000104: {pending mask[7:0] (committed > 0), 16'h0, occupancy of channel 0 [7:0] (DEPTH = 256 reports 8'hFF when full)}.
- other addresses: 32'h0.
- rdata_o holds its value when there is no read.
REQ-025 Any write to 24'h000104 clears drop_cnt. A drop on the same edge leaves drop_cnt = 1.
REQ-026 Writes to any other address, and channel indices >= CHANNELS, are ignored.

Reset
REQ-027 While rst_ni = 0, immediately and asynchronously:
- all FIFOs empty; committed, occupancy and drop_cnt = 0;
- arbiter IDLE, round-robin pointer on channel 0;
- rdata_o = 0, out_valid_o = 0, out_last_o = 0, out_data_o = 0, out_chan_o = 0.
REQ-028 Reset asserted mid-segment discards all buffered bytes; no partial byte is presented after release.
REQ-029 Bus accesses are ignored while rst_ni = 0. The first edge after release accepts accesses normally.

Verification
REQ-030 Write "Hi\n" to ch0 with out_ready_i = 1 -> out_valid_o high 2 edges after the '\n' write; bytes 48,69,0A on chan 0; out_last_o only on 0A.
REQ-031 Write "ab" (no terminator) to ch1 -> no out_valid_o for 20 cycles. Then write 00 -> 61,62,00 emitted, last on 00.
REQ-032 Fill ch2 with DEPTH bytes 0x41, then one more write -> auto-commit, DEPTH bytes output with last on the final one; read 0x100 gives drop_cnt = 1 and full mask bit 2 set before the drain.
REQ-033 Commit "x\n" on ch0, ch1 and ch3 in the same window with out_ready_i toggling 1/0 -> segments emitted in order ch0, ch1, ch3, with data held stable while ready is low, and one IDLE cycle between segments.
REQ-034 Assert rst_ni low during a segment with 3 bytes pending -> out_valid_o drops immediately; after release, reads of 0x100 and 0x104 return 0 except the ADDRESS xor byte.
